// File: rtl/drum_init_writer.sv
// Pyramid initial-displacement generator for the drum mesh: builds a per-ring value
// table, then streams one write per node in row-major order over a valid/ready handshake.
module drum_init_writer #(
  parameter int unsigned  N    = 30,
  parameter int unsigned  W    = 18,
  parameter logic [W-1:0] PEAK = 18'h10000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 wr_en,
  input  logic                 wr_ready,
  output logic [$clog2(N)-1:0] wr_row,
  output logic [$clog2(N)-1:0] wr_col,
  output logic [W-1:0]         wr_data
);

  localparam int unsigned RINGS = N / 2 - 1;
  localparam int unsigned AW    = $clog2(N);
  localparam int unsigned KW    = $clog2(RINGS + 1);

  localparam logic [AW-1:0] LAST    = AW'(N - 1);
  localparam logic [KW-1:0] RINGS_K = KW'(RINGS);
  localparam logic [W-1:0]  RINGS_W = W'(RINGS);
  localparam logic [W-1:0]  QSTEP   = W'(PEAK / RINGS);
  localparam logic [W-1:0]  RSTEP   = W'(PEAK % RINGS);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PREP = 2'd1;
  localparam logic [1:0] S_SCAN = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]    state_q, state_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          wr_en_q, wr_en_d;
  logic [AW-1:0] row_q, row_d;
  logic [AW-1:0] col_q, col_d;
  logic [W-1:0]  data_q, data_d;
  logic [KW-1:0] kcnt_q, kcnt_d;
  logic [W-1:0]  qacc_q, qacc_d;
  logic [W-1:0]  racc_q, racc_d;
  logic [W-1:0]  ring_tbl_q [0:RINGS];

  logic          tbl_we;
  logic [W-1:0]  r_sum;
  logic [AW-1:0] row_nx, col_nx, k_full;
  logic [KW-1:0] k_nx;

  // Distance to the nearest edge is the ring index of a node.
  function automatic logic [AW-1:0] ring_of(input logic [AW-1:0] r, input logic [AW-1:0] c);
    logic [AW-1:0] m;
    m = r;
    if (c < m)        m = c;
    if (LAST - r < m) m = LAST - r;
    if (LAST - c < m) m = LAST - c;
    return m;
  endfunction

  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    wr_en_d = wr_en_q;
    row_d   = row_q;
    col_d   = col_q;
    data_d  = data_q;
    kcnt_d  = kcnt_q;
    qacc_d  = qacc_q;
    racc_d  = racc_q;
    tbl_we  = 1'b0;

    r_sum = racc_q + RSTEP;
    if (col_q == LAST) begin
      col_nx = '0;
      row_nx = row_q + AW'(1);
    end else begin
      col_nx = col_q + AW'(1);
      row_nx = row_q;
    end
    k_full = ring_of(row_nx, col_nx);
    k_nx   = k_full[KW-1:0];

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_PREP;
          busy_d  = 1'b1;
          kcnt_d  = '0;
          qacc_d  = '0;
          racc_d  = '0;
        end
      end
      S_PREP: begin
        // Running quotient/remainder of k*PEAK/RINGS; remainder stays below RINGS.
        tbl_we = 1'b1;
        kcnt_d = kcnt_q + KW'(1);
        if (r_sum >= RINGS_W) begin
          qacc_d = qacc_q + QSTEP + W'(1);
          racc_d = r_sum - RINGS_W;
        end else begin
          qacc_d = qacc_q + QSTEP;
          racc_d = r_sum;
        end
        if (kcnt_q == RINGS_K) begin
          state_d = S_SCAN;
          wr_en_d = 1'b1;
          row_d   = '0;
          col_d   = '0;
          data_d  = '0;
        end
      end
      S_SCAN: begin
        if (wr_ready) begin
          if (row_q == LAST && col_q == LAST) begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            wr_en_d = 1'b0;
            row_d   = '0;
            col_d   = '0;
            data_d  = '0;
          end else begin
            row_d  = row_nx;
            col_d  = col_nx;
            data_d = ring_tbl_q[k_nx];
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      wr_en_q <= 1'b0;
      row_q   <= '0;
      col_q   <= '0;
      data_q  <= '0;
      kcnt_q  <= '0;
      qacc_q  <= '0;
      racc_q  <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      wr_en_q <= wr_en_d;
      row_q   <= row_d;
      col_q   <= col_d;
      data_q  <= data_d;
      kcnt_q  <= kcnt_d;
      qacc_q  <= qacc_d;
      racc_q  <= racc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (tbl_we) ring_tbl_q[kcnt_q] <= qacc_q;
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign wr_en   = wr_en_q;
  assign wr_row  = row_q;
  assign wr_col  = col_q;
  assign wr_data = data_q;

endmodule

// File: tb/tb_drum_init_writer.sv
// Self-checking bench for drum_init_writer: default 30x30 build plus a 4x4 build,
// checked against a closed-form pyramid model and a table of spot values.
module tb_drum_init_writer;

  localparam int N = 30;
  localparam int W = 18;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset, start, wr_ready;
  logic         busy, done, wr_en;
  logic [4:0]   wr_row, wr_col;
  logic [W-1:0] wr_data;

  logic         start4, wr_ready4;
  logic         busy4, done4, wr_en4;
  logic [1:0]   wr_row4, wr_col4;
  logic [W-1:0] wr_data4;

  drum_init_writer #(.N(30), .W(18), .PEAK(18'h10000)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .wr_en(wr_en), .wr_ready(wr_ready), .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data)
  );

  drum_init_writer #(.N(4), .W(18), .PEAK(18'h10000)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .busy(busy4), .done(done4),
    .wr_en(wr_en4), .wr_ready(wr_ready4), .wr_row(wr_row4), .wr_col(wr_col4), .wr_data(wr_data4)
  );

  int checks   = 0;
  int failures = 0;
  logic [W-1:0] dump [0:N-1][0:N-1];

  typedef struct {
    int          r;
    int          c;
    logic [31:0] v;
  } spot_t;
  spot_t spots [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Pyramid height: floor(ring * PEAK / ring_count), ring = distance to nearest edge.
  function automatic int exp_val(input int r, input int c, input int n);
    int k;
    k = r;
    if (c < k)         k = c;
    if (n - 1 - r < k) k = n - 1 - r;
    if (n - 1 - c < k) k = n - 1 - c;
    return (k * 65536) / (n / 2 - 1);
  endfunction

  task automatic check_spots();
    for (int i = 0; i < 6; i++)
      check($sformatf("spot_%0d_%0d", spots[i].r, spots[i].c),
            32'(dump[spots[i].r][spots[i].c]), spots[i].v);
  endtask

  // mode 0: wr_ready always high; mode 1: random ~40% ready duty.
  task automatic run_fill(input int mode, input bit repulse);
    int idx, done_cnt, done_at, first_wr, er, ec;
    idx = 0; done_cnt = 0; done_at = -1; first_wr = -1; er = 0; ec = 0;
    @(negedge clk);
    start = 1'b1;
    for (int i = 1; i <= 6000; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (done_cnt > 0 && i > done_at + 4) break;
      check("busy", 32'(busy), 32'(done_cnt == 0 && !done));
      if (i <= 15 || done_cnt > 0) check("wr_en_idle", 32'(wr_en), 32'd0);
      if (wr_en) begin
        if (first_wr < 0) first_wr = i;
        if (idx < N * N) begin
          er = idx / N;
          ec = idx % N;
          check("wr_row", 32'(wr_row), 32'(er));
          check("wr_col", 32'(wr_col), 32'(ec));
          check($sformatf("wr_data_%0d_%0d", er, ec), 32'(wr_data), 32'(exp_val(er, ec, N)));
        end else begin
          check("extra_write", 32'(idx), 32'(N * N - 1));
        end
      end
      wr_ready = (mode == 0) ? 1'b1 : ($urandom_range(0, 99) < 40);
      if (wr_en && wr_ready) begin
        if (idx < N * N) dump[er][ec] = wr_data;
        idx++;
      end
      if (repulse && wr_en && idx == 100) start = 1'b1;
      if (done) begin
        done_cnt++;
        done_at = i;
        if (repulse) start = 1'b1;
      end
    end
    start = 1'b0;
    check("write_count", 32'(idx), 32'(N * N));
    check("done_pulses", 32'(done_cnt), 32'd1);
    if (mode == 0) begin
      check("first_wr_cycle", 32'(first_wr), 32'd16);
      check("done_cycle", 32'(done_at), 32'd916);
    end
  endtask

  task automatic reset_mid_stall();
    int idx;
    bit hit;
    idx = 0;
    hit = 1'b0;
    wr_ready = 1'b1;
    @(negedge clk);
    start = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (wr_en && idx == 12 * N + 3) begin
        wr_ready = 1'b0;
        hit = 1'b1;
        break;
      end
      if (wr_en) idx++;
    end
    check("reach_node", 32'(hit), 32'd1);
    for (int s = 0; s < 3; s++) begin
      check("stall_row", 32'(wr_row), 32'd12);
      check("stall_col", 32'(wr_col), 32'd3);
      check("stall_data", 32'(wr_data), 32'h036DB);
      check("stall_wr_en", 32'(wr_en), 32'd1);
      @(negedge clk);
    end
    #2 reset = 1'b1;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_row", 32'(wr_row), 32'd0);
    check("rst_col", 32'(wr_col), 32'd0);
    check("rst_data", 32'(wr_data), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    wr_ready = 1'b1;
  endtask

  task automatic run_small();
    int idx, done_cnt, r4, c4;
    idx = 0; done_cnt = 0;
    @(negedge clk);
    start4 = 1'b1;
    for (int i = 1; i <= 300; i++) begin
      @(negedge clk);
      start4 = 1'b0;
      if (done4) done_cnt++;
      if (done_cnt > 0 && !done4) break;
      if (wr_en4) begin
        r4 = idx / 4;
        c4 = idx % 4;
        check("n4_row", 32'(wr_row4), 32'(r4));
        check("n4_col", 32'(wr_col4), 32'(c4));
        check($sformatf("n4_data_%0d_%0d", r4, c4), 32'(wr_data4), 32'(exp_val(r4, c4, 4)));
      end
      wr_ready4 = ($urandom_range(0, 1) == 1);
      if (wr_en4 && wr_ready4) idx++;
    end
    check("n4_writes", 32'(idx), 32'd16);
    check("n4_done_pulses", 32'(done_cnt), 32'd1);
  endtask

  initial begin
    spots = '{'{0, 5, 32'h00000}, '{1, 1, 32'h01249}, '{5, 10, 32'h05B6D},
              '{7, 7, 32'h08000}, '{13, 13, 32'h0EDB6}, '{14, 15, 32'h10000}};
    reset = 1'b1; start = 1'b0; wr_ready = 1'b0; start4 = 1'b0; wr_ready4 = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_wr_en", 32'(wr_en), 32'd0);
    check("reset_row", 32'(wr_row), 32'd0);
    check("reset_col", 32'(wr_col), 32'd0);
    check("reset_data", 32'(wr_data), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // T1/T2: full-rate fill, timing and full dump
    run_fill(0, 1'b0);
    check_spots();
    // T3: random back-pressure
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) dump[r][c] = '1;
    run_fill(1, 1'b0);
    check_spots();
    // T4: start re-pulsed during SCAN and DONE
    run_fill(0, 1'b1);
    repeat (5) begin
      @(negedge clk);
      check("idle_after_repulse", 32'(busy), 32'd0);
    end
    // T5: reset mid-stall, then a clean fill
    reset_mid_stall();
    run_fill(0, 1'b0);
    check_spots();
    // T6: 4x4 build
    run_small();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
